uart_packetizer: RTL and testbench

Packet framer sitting directly upstream of the team's UART transmitter. It collects payload bytes from a valid/ready byte stream into a single packet buffer. It then drives the transmitter's start/data/done handshake one byte at a time to emit the frame SOF, LEN, payload[0..LEN-1], CHK. It is single-buffered: input is stalled while a frame is on the wire.

---
 rtl/uart_packetizer.sv | 89 ++++++++
 tb/tb_uart_packetizer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_packetizer.sv
// uart_packetizer: buffers one payload packet, then frames it as SOF, LEN, payload, CHK over the UART transmitter handshake.
module uart_packetizer #(
  parameter int DATA_BITS = 8,
  parameter int MAX_PAYLOAD = 16,
  parameter logic [DATA_BITS-1:0] SOF_BYTE = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 tx_start,
  output logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_done,
  output logic                 busy,
  output logic                 pkt_done
);
  localparam int CW = $clog2(MAX_PAYLOAD + 1);
  localparam int IW = MAX_PAYLOAD > 1 ? $clog2(MAX_PAYLOAD) : 1;
  typedef enum logic [2:0] {COLLECT, TX_SOF, TX_LEN, TX_PAY, TX_CHK} state_t;
  state_t r_state, w_next_state;
  logic [CW-1:0] r_count;
  logic [IW-1:0] r_idx, w_next_idx;
  logic [DATA_BITS-1:0] r_xor, w_tx_data;
  logic [DATA_BITS-1:0] r_buf [MAX_PAYLOAD];
  logic w_accept, w_close, w_done, w_pay_last, w_issue;
  assign w_accept = in_valid & in_ready;
  assign w_close = w_accept & (in_last | r_count == CW'(MAX_PAYLOAD - 1));
  assign w_done = tx_done & ~tx_start & (r_state != COLLECT);
  assign w_pay_last = CW'(r_idx) == r_count - CW'(1);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= COLLECT;
      r_idx <= '0;
    end else begin
      r_state <= w_next_state;
      r_idx <= w_next_idx;
    end
  end
  always_comb begin
    w_next_state = r_state;
    w_next_idx = r_idx;
    case (r_state)
      COLLECT: if (w_close) w_next_state = TX_SOF;
      TX_SOF:  if (w_done) w_next_state = TX_LEN;
      TX_LEN: if (w_done) begin
        w_next_state = TX_PAY;
        w_next_idx = '0;
      end
      TX_PAY: if (w_done) begin
        w_next_state = w_pay_last ? TX_CHK : TX_PAY;
        w_next_idx = w_pay_last ? r_idx : r_idx + IW'(1);
      end
      default: if (w_done) w_next_state = COLLECT;
    endcase
  end
  always_comb begin
    w_issue = r_state == COLLECT ? w_close : w_done && r_state != TX_CHK;
    w_tx_data = w_next_state == TX_SOF ? SOF_BYTE :
                w_next_state == TX_LEN ? DATA_BITS'(r_count) :
                w_next_state == TX_PAY ? r_buf[w_next_idx] : DATA_BITS'(r_count) ^ r_xor;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready <= 1'b1;
      tx_start <= 1'b0;
      tx_data <= '0;
      busy <= 1'b0;
      pkt_done <= 1'b0;
    end else begin
      in_ready <= w_next_state == COLLECT;
      busy <= w_next_state != COLLECT;
      tx_start <= w_issue;
      if (w_issue) tx_data <= w_tx_data;
      pkt_done <= r_state == TX_CHK && w_done;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || (r_state == TX_CHK && w_done)) begin
      r_count <= '0;
      r_xor <= '0;
    end else if (w_accept) begin
      r_count <= r_count + CW'(1);
      r_xor <= r_xor ^ in_data;
    end
  end
  always_ff @(posedge clk) if (w_accept) r_buf[r_count[IW-1:0]] <= in_data;
endmodule

// File: tb/tb_uart_packetizer.sv
// tb_uart_packetizer: random and directed packets against a frame-level queue model with a delayed-done transmitter.
module tb_uart_packetizer;
  logic clk = 0, rst = 1, in_valid = 0, in_last = 0, tx_done = 0;
  logic [7:0] in_data = 0, tx_data;
  logic in_ready, tx_start, busy, pkt_done;
  int n_cmp = 0, n_err = 0;
  int exp_q[$];
  logic [7:0] pay_q[$];
  logic [7:0] m_xor = 0, held = 0;
  int pend = 0, dmin = 1, dmax = 4;
  bit active = 0, close_pend = 0, pkt_exp = 0, start_exp = 0, cur_last = 0;
  bit spur = 0, inj_issue = 0, want_b2b = 0;

  uart_packetizer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
    .busy(busy), .pkt_done(pkt_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, want, $time);
    end
  endtask

  // One cycle: observe outputs at the falling edge and run the transmitter model.
  task automatic tick();
    int e;
    @(negedge clk);
    chk("pkt_done", 32'(pkt_done), 32'(pkt_exp));
    if (pkt_exp) active = 0;
    if (close_pend) active = 1;
    pkt_exp = 0;
    close_pend = 0;
    chk("in_ready", 32'(in_ready), 32'(!active));
    chk("busy", 32'(busy), 32'(active));
    if (start_exp) chk("issue_latency", 32'(tx_start), 32'd1);
    start_exp = 0;
    tx_done = spur;
    spur = 0;
    if (tx_start) begin
      chk("start_in_wait", 32'(pend), 32'd0);
      if (exp_q.size() == 0) chk("unexpected_start", 32'(tx_start), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("tx_data", 32'(tx_data), 32'(e[7:0]));
        cur_last = e[8];
      end
      held = tx_data;
      pend = int'($urandom_range(dmax, dmin));
      if (inj_issue) begin
        tx_done = 1;
        inj_issue = 0;
      end
    end else if (pend > 0) begin
      chk("tx_data_hold", 32'(tx_data), 32'(held));
      pend--;
      if (pend == 0) begin
        tx_done = 1;
        pkt_exp = cur_last;
        start_exp = !cur_last;
      end
    end
  endtask

  task automatic close_pkt();
    exp_q.push_back(32'hA5);
    exp_q.push_back(pay_q.size());
    foreach (pay_q[i]) exp_q.push_back(32'(pay_q[i]));
    exp_q.push_back(32'h100 | (pay_q.size() ^ 32'(m_xor)));
    pay_q.delete();
    m_xor = 0;
    close_pend = 1;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit last);
    int n = 0;
    in_valid = 1;
    in_data = d;
    in_last = last;
    while (!in_ready && n < 40000) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 0;
      return;
    end
    if (want_b2b) chk("accept_on_pkt_done", 32'(pkt_done), 32'd1);
    want_b2b = 0;
    pay_q.push_back(d);
    m_xor ^= d;
    if (last || pay_q.size() == 16) close_pkt();
    tick();
    in_valid = 0;
    in_last = 0;
    in_data = 8'($urandom);
  endtask

  task automatic send_pkt(input logic [7:0] b[$], input bit use_last, input bit gaps);
    foreach (b[i]) begin
      send_byte(b[i], use_last && i == b.size() - 1);
      if (gaps) repeat ($urandom_range(2, 0)) tick();
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((active || close_pend || pkt_exp || pend > 0 || exp_q.size() > 0) && n < 50000) begin
      tick();
      n++;
    end
    if (n >= 50000) chk("frame_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] p[$];
    int n;
    repeat (3) tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pkt_done", 32'(pkt_done), 32'd0);
    rst = 0;
    tick();
    p = '{8'h11, 8'h22, 8'h33};
    send_pkt(p, 1, 0);
    wait_idle();
    p = '{8'h5A};
    send_pkt(p, 1, 0);
    wait_idle();
    p.delete();
    for (int i = 0; i < 16; i++) p.push_back(i[7:0]);
    send_pkt(p, 0, 0);
    want_b2b = 1;
    send_byte(8'hEE, 0);
    send_byte(8'h01, 1);
    wait_idle();
    dmin = 1000;
    dmax = 1000;
    p = '{8'hC3, 8'h3C};
    send_pkt(p, 1, 0);
    wait_idle();
    dmin = 1;
    dmax = 4;
    spur = 1;
    repeat (3) tick();
    chk("spurious_done_no_start", 32'(tx_start), 32'd0);
    p = '{8'h77};
    send_pkt(p, 1, 0);
    wait_idle();
    p = '{8'h10, 8'h20, 8'h30, 8'h40};
    send_pkt(p, 1, 0);
    n = 0;
    while (exp_q.size() > 3 && n < 1000) begin
      tick();
      n++;
    end
    chk("reach_pay_idx1", 32'(exp_q.size()), 32'd3);
    rst = 1;
    exp_q.delete();
    pend = 0;
    pkt_exp = 0;
    start_exp = 0;
    active = 0;
    close_pend = 0;
    pay_q.delete();
    m_xor = 0;
    tx_done = 0;
    tick();
    chk("midrst_tx_start", 32'(tx_start), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_pkt_done", 32'(pkt_done), 32'd0);
    rst = 0;
    tick();
    p = '{8'h01};
    send_pkt(p, 1, 0);
    wait_idle();
    p = '{8'hAB, 8'hCD};
    send_pkt(p, 1, 0);
    want_b2b = 1;
    p = '{8'h12, 8'h34};
    send_pkt(p, 1, 0);
    wait_idle();
    dmax = 6;
    for (int k = 0; k < 40; k++) begin
      int len;
      bit b2b;
      len = int'($urandom_range(16, 1));
      b2b = $urandom_range(1, 0) == 1;
      inj_issue = $urandom_range(3, 0) == 0;
      p.delete();
      for (int i = 0; i < len; i++) p.push_back(8'($urandom));
      send_pkt(p, len < 16 || $urandom_range(1, 0) == 1, 1);
      if (b2b && k < 39) want_b2b = 1;
      else wait_idle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
